// File: rtl/alu_pkg.sv
// Shared opcode/state encodings for the sequential ALU and its mul/div engine.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_SRA   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REM   = 4'd14,
    OP_REMU  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_iterative(input alu_op_e op);
    return 4'(op) >= 4'(OP_MUL);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// WIDTH-cycle shift-add multiplier / restoring divider on unsigned magnitudes.
// The *_o values are the post-step results, valid in the cycle done_o is high.
module seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             kind_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_hi_o,
  output logic [WIDTH-1:0] product_lo_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             run_q;
  logic             kind_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] hi_q, lo_q, opb_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, rsh, diff;

  assign a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // hi holds the upper product half / partial remainder, lo the multiplier / quotient.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    sum  = '0;
    rsh  = '0;
    diff = '0;
    if (!kind_q) begin
      sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
    end else begin
      rsh  = {hi_q, lo_q[WIDTH-1]};
      diff = rsh - {1'b0, opb_q};
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rsh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done_o       = run_q && (count_q == CW'(WIDTH - 1));
  assign product_hi_o = hi_d;
  assign product_lo_o = lo_d;
  assign quotient_o   = lo_d;
  assign remainder_o  = hi_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      kind_q  <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
    end else if (start_i) begin
      run_q   <= 1'b1;
      kind_q  <= kind_i;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= a_mag;
      opb_q   <= b_mag;
    end else if (run_q) begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops and divide special cases finish in one cycle,
// MUL/DIV families run on the iterative engine; results held until consumed.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q;
  alu_op_e          op_q;
  alu_op_e          op_e;
  logic             out_valid_q, zero_q, qneg_q, rneg_q;
  logic [WIDTH-1:0] result_q, fast_res, iter_res;
  logic [SHW-1:0]   shamt;
  logic             is_div_op, is_sdiv, special, accept, start_iter;
  logic             eng_done;
  logic [WIDTH-1:0] eng_hi, eng_lo, eng_quo, eng_rem;

  assign op_e       = alu_op_e'(op);
  assign shamt      = b[SHW-1:0];
  assign is_div_op  = (op[3:2] == 2'b11);
  assign is_sdiv    = (op_e == OP_DIV) || (op_e == OP_REM);
  assign special    = is_div_op && ((b == '0) || (is_sdiv && a == MOST_NEG && b == '1));
  assign in_ready   = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept     = in_valid && in_ready;
  assign start_iter = accept && is_iterative(op_e) && !special;

  // Divide arms only cover the special cases; ordinary divides go iterative.
  always_comb begin
    fast_res = '0;
    case (op_e)
      OP_ADD:             fast_res = a + b;
      OP_SUB:             fast_res = a - b;
      OP_AND:             fast_res = a & b;
      OP_OR:              fast_res = a | b;
      OP_XOR:             fast_res = a ^ b;
      OP_SLT:             fast_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLL:             fast_res = a << shamt;
      OP_SRL:             fast_res = a >> shamt;
      OP_SRA:             fast_res = $unsigned($signed(a) >>> shamt);
      OP_SLTU:            fast_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_DIV, OP_DIVU:    fast_res = (b == '0) ? '1 : a;
      OP_REM, OP_REMU:    fast_res = (b == '0) ? a : '0;
      default:            fast_res = '0;
    endcase
  end

  always_comb begin
    iter_res = '0;
    case (op_q)
      OP_MUL:          iter_res = eng_lo;
      OP_MULHU:        iter_res = eng_hi;
      OP_DIV, OP_DIVU: iter_res = qneg_q ? -eng_quo : eng_quo;
      default:         iter_res = rneg_q ? -eng_rem : eng_rem;
    endcase
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_iter),
    .kind_i       (is_div_op),
    .signed_i     (is_sdiv),
    .a_i          (a),
    .b_i          (b),
    .done_o       (eng_done),
    .product_hi_o (eng_hi),
    .product_lo_o (eng_lo),
    .quotient_o   (eng_quo),
    .remainder_o  (eng_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            op_q   <= op_e;
            qneg_q <= is_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q <= is_sdiv && a[WIDTH-1];
            if (start_iter) begin
              state_q     <= is_div_op ? DIV : MUL;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= fast_res;
              zero_q      <= (fast_res == '0);
            end
          end
        end
        MUL, DIV: begin
          if (eng_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= iter_res;
            zero_q      <= (iter_res == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = (state_q == MUL) || (state_q == DIV);

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds the RV32M-style multiply/divide ops via an iterative engine, plus sra and sltu.
- All results are registered behind a valid/ready interface.
- Sits between decode/issue and writeback; the core stalls on in_ready/out_valid instead of assuming a fixed latency.

Parameters:
- WIDTH, 32: operand/result width; must be a power of 2, >= 8.
- SHW, $clog2(WIDTH): shift-amount bits taken from b (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  operation code (alu_op_e, see package).
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result this cycle.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0; registered alongside result.
- busy  out  1  iterative operation in progress.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL.
  - 8 SRA, 9 SLTU, 10 MUL (low WIDTH), 11 MULHU (high WIDTH, unsigned).
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Shifts use b[SHW-1:0] only. SLT/SLTU return {0..0, flag}.
- Accept: a transfer occurs when in_valid && in_ready. Operands and op are latched on accept; later input changes are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready), which allows back-to-back issue.
- FSM states:
  - IDLE: on accept of ops 0-9, or of a divide special case, compute combinationally and go to DONE. On accept of ops 10-15 otherwise, go to MUL or DIV with count=0.
  - MUL: shift-add over 2*WIDTH accumulator, one bit per cycle. After WIDTH iterations go to DONE.
  - DIV: restoring division on magnitudes, one quotient bit per cycle. After WIDTH iterations, fix signs and go to DONE.
  - DONE: out_valid=1, result and zero stable. On out_ready: go to IDLE, or take a new accept in the same cycle.
- Latency, from accept edge N:
  - Ops 0-9 and divide special cases: out_valid at N+1.
  - MUL/MULHU: out_valid at N+WIDTH+1.
  - DIV/DIVU/REM/REMU: out_valid at N+WIDTH+1.
- Sign/width rules:
  - DIV/REM are signed; the quotient is negated when signs differ; the remainder takes the sign of the dividend.
  - MUL low half is sign-agnostic. MULHU treats both operands as unsigned.
- Divide special cases:
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow (a = most-negative, b = -1): DIV -> a; REM -> 0.
- busy = (state==MUL || state==DIV).
- Backpressure: with out_ready low in DONE, result and zero hold indefinitely and in_ready=0.
- Reset, including mid-operation: state=IDLE, count=0, out_valid=0, result=0, zero=0, busy=0. Any in-flight operation is discarded and no result is produced.
- An in_valid asserted during the reset cycle is not accepted.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (4-bit, encodings above).
  - state_e enum {IDLE, MUL, DIV, DONE}.
  - Helper function is_iterative(op).
- Sub-module seq_muldiv holds the WIDTH-cycle shift-add/restoring-divide engine and its counter:
  - Inputs: start, kind, signed flags, operands.
  - Outputs: done, product_hi/lo, quotient, remainder.
- seq_alu keeps the single-cycle ops, special-case detection, sign fixing and the handshake FSM.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid at N+1, result=0x80000000, zero=0. Then SUB a=5, b=5 -> result 0, zero=1.
- SRA a=0x80000010, b=0x24 (shift 4) -> 0xF8000001. SLTU a=1, b=0xFFFFFFFF -> 1. SLT with same operands -> 0.
- MULHU a=b=0xFFFFFFFF -> busy for 32 cycles, out_valid at N+33, result=0xFFFFFFFE. MUL with same operands -> 0x00000001.
- DIV a=-7, b=2 -> quotient 0xFFFFFFFD (-3); REM with same operands -> 0xFFFFFFFF (-1). DIVU a=5, b=0 -> 0xFFFFFFFF at N+1. DIV a=0x80000000, b=-1 -> 0x80000000 at N+1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Raise out_ready with in_valid=1 (ADD 2+3) -> same-cycle accept, result 5 next cycle.
- Reset mid-DIV: rst_n=0 at iteration 10 -> next cycle out_valid=0, busy=0, result=0, in_ready=1. A fresh ADD completes normally.
